ifu_fetch_issue: RTL and testbench



---
 rtl/ifu_fetch_issue_pkg.sv | 32 +++
 rtl/ifu_fetch_issue_if.sv | 38 +++
 rtl/ifu_pc_reg.sv | 39 +++
 rtl/ifu_fetch_issue.sv | 151 +++++++++++++++
 tb/tb_ifu_fetch_issue.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_issue_pkg.sv
// Shared constants for the instruction fetch/issue path.
// The control unit imports the same opcode constants so both ends of the
// opcode path agree on encodings.
package ifu_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_W   = 7;
   localparam int REG_W   = 3;

   localparam logic [OPC_W-1:0] OPC_IADD = 7'b0100000;
   localparam logic [OPC_W-1:0] OPC_HLT  = 7'b1100001;

   // instruction word field positions
   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 9;
   localparam int RSRC_MSB = 8;
   localparam int RSRC_LSB = 6;
   localparam int RDST_MSB = 5;
   localparam int RDST_LSB = 3;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_IMM,
      ST_ISSUE,
      ST_HALT
   } ifu_state_e;

   function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] word);
      return word[OPC_MSB:OPC_LSB];
   endfunction

endpackage

// File: rtl/ifu_fetch_issue_if.sv
// Instruction-memory request/ack bus and issue valid/ready bus of the fetch unit.
// master: the fetch/issue unit; slave: instruction memory plus control unit.
interface ifu_fetch_issue_if #(
   parameter int ADDR_W = 16
);
   import ifu_pkg::*;

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [INSTR_W-1:0]  imem_rdata;

   logic                iss_valid;
   logic                iss_ready;
   logic [OPC_W-1:0]    iss_opcode;
   logic [REG_W-1:0]    iss_rsrc;
   logic [REG_W-1:0]    iss_rdst;
   logic [INSTR_W-1:0]  iss_imm;
   logic [ADDR_W-1:0]   iss_pc;
   logic                halted;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      output iss_valid,
      input  iss_ready,
      output iss_opcode, iss_rsrc, iss_rdst, iss_imm, iss_pc, halted
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      input  iss_valid,
      output iss_ready,
      input  iss_opcode, iss_rsrc, iss_rdst, iss_imm, iss_pc, halted
   );

endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter: holds the fetch address, increments with natural
// wrap at ADDR_W bits, and can be loaded with an absolute target.
module ifu_pc_reg #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc_en,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_pc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_d;
   logic [ADDR_W-1:0] pc_q;

   // next PC: a load overrides any increment in the same cycle
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_pc;
      end else if (inc_en) begin
         pc_d = pc_q + ADDR_W'(1);
      end
   end

   // PC register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch_issue.sv
// Instruction fetch and issue unit: fetches 16-bit words over req/ack,
// joins IADD with its immediate word and issues over valid/ready.
// Optional redirect input port pair enabled by macro IFU_REDIRECT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | request word at pc; on ack latch fields, pc+1
// ST_IMM   | request IADD immediate at pc; on ack latch imm, pc+1
// ST_ISSUE | iss_valid high, fields frozen until iss_ready
// ST_HALT  | HLT issued; no more fetching until reset
module ifu_fetch_issue
   import ifu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
`ifdef IFU_REDIRECT_EN
   input  logic              redir_valid,
   input  logic [ADDR_W-1:0] redir_pc,
`endif
   ifu_fetch_issue_if.master bus
);

   ifu_state_e          state_q, state_d;
   logic                imem_req_q, imem_req_d;
   logic                iss_valid_q, iss_valid_d;
   logic                halted_q, halted_d;
   logic [OPC_W-1:0]    opcode_q, opcode_d;
   logic [REG_W-1:0]    rsrc_q, rsrc_d;
   logic [REG_W-1:0]    rdst_q, rdst_d;
   logic [INSTR_W-1:0]  imm_q, imm_d;
   logic [ADDR_W-1:0]   iss_pc_q, iss_pc_d;

   logic                pc_inc;
   logic                pc_load;
   logic [ADDR_W-1:0]   pc_load_val;
   logic [ADDR_W-1:0]   pc;
   logic                redir;
   logic                ack_ok;

`ifdef IFU_REDIRECT_EN
   assign redir       = redir_valid && (state_q != ST_HALT);
   assign pc_load_val = redir_pc;
`else
   assign redir       = 1'b0;
   assign pc_load_val = '0;
`endif

   // an ack only counts against an outstanding request
   assign ack_ok  = bus.imem_ack && imem_req_q;
   assign pc_load = redir;

   ifu_pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .reset   (reset),
      .inc_en  (pc_inc),
      .load_en (pc_load),
      .load_pc (pc_load_val),
      .pc      (pc)
   );

   // next state, latched fields and registered handshake outputs
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      rsrc_d   = rsrc_q;
      rdst_d   = rdst_q;
      imm_d    = imm_q;
      iss_pc_d = iss_pc_q;
      pc_inc   = 1'b0;

      if (redir) begin
         // redirect abandons any fetch in flight, including a same-cycle ack
         state_d = ST_FETCH;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (ack_ok) begin
                  opcode_d = instr_opcode(bus.imem_rdata);
                  rsrc_d   = bus.imem_rdata[RSRC_MSB:RSRC_LSB];
                  rdst_d   = bus.imem_rdata[RDST_MSB:RDST_LSB];
                  imm_d    = '0;
                  iss_pc_d = pc;
                  pc_inc   = 1'b1;
                  state_d  = (instr_opcode(bus.imem_rdata) == OPC_IADD) ? ST_IMM : ST_ISSUE;
               end
            end
            ST_IMM: begin
               if (ack_ok) begin
                  imm_d   = bus.imem_rdata;
                  pc_inc  = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.iss_ready) begin
                  state_d = (opcode_q == OPC_HLT) ? ST_HALT : ST_FETCH;
               end
            end
            default: begin
               state_d = ST_HALT;
            end
         endcase
      end

      imem_req_d  = (state_d == ST_FETCH) || (state_d == ST_IMM);
      iss_valid_d = (state_d == ST_ISSUE);
      halted_d    = (state_d == ST_HALT);
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_FETCH;
         imem_req_q  <= 1'b0;
         iss_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         opcode_q    <= '0;
         rsrc_q      <= '0;
         rdst_q      <= '0;
         imm_q       <= '0;
         iss_pc_q    <= RESET_PC;
      end else begin
         state_q     <= state_d;
         imem_req_q  <= imem_req_d;
         iss_valid_q <= iss_valid_d;
         halted_q    <= halted_d;
         opcode_q    <= opcode_d;
         rsrc_q      <= rsrc_d;
         rdst_q      <= rdst_d;
         imm_q       <= imm_d;
         iss_pc_q    <= iss_pc_d;
      end
   end

   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = pc;
   assign bus.iss_valid  = iss_valid_q;
   assign bus.iss_opcode = opcode_q;
   assign bus.iss_rsrc   = rsrc_q;
   assign bus.iss_rdst   = rdst_q;
   assign bus.iss_imm    = imm_q;
   assign bus.iss_pc     = iss_pc_q;
   assign bus.halted     = halted_q;

endmodule

// File: tb/tb_ifu_fetch_issue.sv
// Bench for ifu_fetch_issue: random programs against a program-walking
// reference model, plus a 4-bit-address instance for PC wrap.
`timescale 1ns/1ps
module tb_ifu_fetch_issue;

   localparam logic [6:0] T_IADD = 7'b0100000;
   localparam logic [6:0] T_HLT  = 7'b1100001;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem [0:255];
   logic [44:0] exp_q [$];
   int          exp_hlt_pc = 0;

   bit mon_en    = 0;
   bit spur_mode = 0;
   bit fast      = 1;
   bit run1      = 1;
   bit stalled4  = 0;
   int stall_cnt = 0;
   int m_cnt     = 0;
   int m_lat     = 1;

   int          w_cnt = 0;
   int          w_addrs [$];
   logic [26:0] w_first = '0;
   bit          w_first_seen = 0;

   ifu_fetch_issue_if #(.ADDR_W(16)) bus ();
   ifu_fetch_issue_if #(.ADDR_W(4))  w_if ();

`ifdef IFU_REDIRECT_EN
   logic        redir_valid   = 1'b0;
   logic [15:0] redir_pc      = '0;
   logic        w_redir_valid = 1'b0;
   logic [3:0]  w_redir_pc    = '0;
`endif

   ifu_fetch_issue #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .reset       (reset),
`ifdef IFU_REDIRECT_EN
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
`endif
      .bus         (bus)
   );

   ifu_fetch_issue #(.ADDR_W(4), .RESET_PC(4'hF)) dut_wrap (
      .clk         (clk),
      .reset       (reset),
`ifdef IFU_REDIRECT_EN
      .redir_valid (w_redir_valid),
      .redir_pc    (w_redir_pc),
`endif
      .bus         (w_if)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expd);
      n_vec++;
      if (obs !== expd) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expd);
      end
   endtask

   function automatic logic [15:0] rand_one();
      logic [6:0] op;
      do op = 7'($urandom); while (op == T_IADD || op == T_HLT);
      return {op, 9'($urandom)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   // random program body from start up to len-1, HLT at len
   task automatic gen_prog(input int start, input int len);
      int i;
      i = start;
      while (i < len) begin
         if ($urandom_range(0, 3) == 0 && i + 1 < len) begin
            mem[i]     = {T_IADD, 9'($urandom)};
            mem[i + 1] = 16'($urandom);
            i += 2;
         end else begin
            mem[i] = rand_one();
            i += 1;
         end
      end
      mem[len] = {T_HLT, 9'($urandom)};
   endtask

   // walk the program as the control unit would see it, up to and including HLT
   task automatic build_exp(input int start);
      int          pc;
      logic [15:0] w;
      logic [15:0] imm;
      pc = start;
      exp_q.delete();
      for (int n = 0; n < 256; n++) begin
         w   = mem[pc % 256];
         imm = 16'h0000;
         if (w[15:9] == T_IADD) imm = mem[(pc + 1) % 256];
         exp_q.push_back({w[15:9], w[8:6], w[5:3], imm, 16'(pc)});
         if (w[15:9] == T_HLT) begin
            exp_hlt_pc = pc;
            break;
         end
         pc += (w[15:9] == T_IADD) ? 2 : 1;
      end
   endtask

   function automatic int lat_for(input logic [15:0] a);
      if (run1 && (a == 16'd4 || a == 16'd5)) return 3;
      if (fast) return 1;
      return int'($urandom_range(1, 3));
   endfunction

   // instruction memory: ack arrives m_lat cycles after the request is first seen
   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (!reset) begin
            bus.imem_ack = 1'b0;
            m_cnt = 0;
         end else if (spur_mode) begin
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = 16'($urandom);
         end else begin
            bus.imem_ack = 1'b0;
            if (bus.imem_req) begin
               if (m_cnt == 0) m_lat = lat_for(bus.imem_addr);
               m_cnt++;
               if (m_cnt > m_lat) begin
                  bus.imem_ack   = 1'b1;
                  bus.imem_rdata = mem[bus.imem_addr[7:0]];
                  m_cnt = 0;
               end
            end else begin
               m_cnt = 0;
            end
         end
      end
   end

   // downstream ready: random, with one forced 5-cycle stall on the IADD at 4
   initial begin
      bus.iss_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (run1 && !stalled4 && bus.iss_valid && bus.iss_pc == 16'd4) begin
            stalled4  = 1;
            stall_cnt = 5;
         end
         if (stall_cnt > 0) begin
            bus.iss_ready = 1'b0;
            stall_cnt--;
         end else begin
            bus.iss_ready = ($urandom_range(0, 99) < 70);
         end
      end
   end

   // issue scoreboard and protocol checks
   initial begin
      logic [44:0] prev_f;
      logic [15:0] prev_addr;
      bit          prev_stall;
      bit          prev_hs;
      logic [44:0] cur_f;
      prev_f = '0; prev_addr = '0; prev_stall = 0; prev_hs = 0;
      forever begin
         @(negedge clk);
         cur_f = {bus.iss_opcode, bus.iss_rsrc, bus.iss_rdst, bus.iss_imm, bus.iss_pc};
         if (mon_en && reset) begin
            if (prev_stall)
               check_val("hold", {bus.iss_valid, bus.imem_req, cur_f, bus.imem_addr},
                         {1'b1, 1'b0, prev_f, prev_addr});
            if (prev_hs)
               check_val("gap_after_issue", bus.iss_valid, 1'b0);
            if (bus.iss_valid && bus.iss_ready) begin
               if (exp_q.size() == 0) check_val("extra_issue", bus.iss_valid, 1'b0);
               else check_val("issue", cur_f, exp_q.pop_front());
            end
            prev_stall = bus.iss_valid && !bus.iss_ready;
            prev_hs    = bus.iss_valid && bus.iss_ready;
            prev_f     = cur_f;
            prev_addr  = bus.imem_addr;
         end else begin
            prev_stall = 0;
            prev_hs    = 0;
         end
      end
   end

   // wrap instance: 1-cycle memory, always ready; IADD at 15, immediate at 0
   initial begin
      w_if.imem_ack   = 1'b0;
      w_if.imem_rdata = 16'h0000;
      w_if.iss_ready  = 1'b1;
      forever begin
         @(posedge clk); #1;
         w_if.imem_ack = 1'b0;
         if (!reset) begin
            w_cnt = 0;
         end else if (w_if.imem_req) begin
            w_cnt++;
            if (w_cnt > 1) begin
               w_if.imem_ack   = 1'b1;
               w_if.imem_rdata = (w_if.imem_addr == 4'hF) ? 16'h4000 :
                                 (w_if.imem_addr == 4'h0) ? 16'h1234 : 16'h0000;
               if (w_addrs.size() < 3) w_addrs.push_back(int'(w_if.imem_addr));
               w_cnt = 0;
            end
         end else begin
            w_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (reset && !w_first_seen && w_if.iss_valid && w_if.iss_ready) begin
            w_first      = {w_if.iss_opcode, w_if.iss_imm, w_if.iss_pc};
            w_first_seen = 1;
         end
      end
   end

   function automatic logic [47:0] rst_vec();
      return {bus.imem_req, bus.iss_valid, bus.halted, bus.iss_opcode, bus.iss_rsrc,
              bus.iss_rdst, bus.iss_imm, bus.iss_pc};
   endfunction

   task automatic run_to_halt(input string tag);
      int cyc;
      cyc = 0;
      while (!bus.halted && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val({tag, "_halted"}, bus.halted, 1'b1);
      @(negedge clk);
      check_val({tag, "_all_issued"}, exp_q.size(), 0);
   endtask

   task automatic reset_pulse();
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check_val("async_reset_vals", rst_vec(), 48'h0);
   endtask

   initial begin
      int wrap_exp [3];
      wrap_exp = '{15, 0, 1};

      // run 1: directed prefix then random body
      clear_mem();
      mem[0] = 16'h2248;
      for (int a = 1; a < 4; a++) mem[a] = rand_one();
      mem[4] = 16'h4000;
      mem[5] = 16'hBEEF;
      gen_prog(6, 60);
      build_exp(0);

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_vals", rst_vec(), 48'h0);
      mon_en = 1;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("cycle1_req_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});
      repeat (2) @(posedge clk);
      #1;
      check_val("cycle3_issue",
                {bus.iss_valid, bus.iss_opcode, bus.iss_rsrc, bus.iss_rdst, bus.iss_imm, bus.iss_pc},
                {1'b1, 7'b0010001, 3'd1, 3'd1, 16'h0000, 16'h0000});
      fast = 0;
      run_to_halt("run1");

      spur_mode = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_val("halt_hold", {bus.imem_req, bus.iss_valid, bus.halted, bus.imem_addr},
                   {1'b0, 1'b0, 1'b1, 16'(exp_hlt_pc + 1)});
      end
      spur_mode = 0;
      run1 = 0;

      // run 2: fresh program after reset, with a reset abort mid-request
      reset_pulse();
      clear_mem();
      gen_prog(0, 50);
      build_exp(0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("resume_req_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});
      #2;
      reset = 1'b0;
      #1;
      check_val("abort_req_valid", {bus.imem_req, bus.iss_valid}, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check_val("restart_req_addr", {bus.imem_req, bus.imem_addr}, {1'b1, 16'h0000});
      run_to_halt("run2");

`ifdef IFU_REDIRECT_EN
      begin
         int cyc;
         reset_pulse();
         fast = 1;
         clear_mem();
         mem[0]  = 16'h4000;
         mem[1]  = 16'hBEEF;
         mem[32] = 16'h2248;
         mem[33] = 16'hC200;
         build_exp(32);
         @(negedge clk);
         reset = 1'b1;
         cyc = 0;
         do begin
            @(posedge clk); #1;
            cyc++;
         end while (!(bus.imem_req && bus.imem_addr == 16'd1) && cyc < 20);
         check_val("redir_imm_req", {bus.imem_req, bus.imem_addr}, {1'b1, 16'd1});
         @(posedge clk); #1;
         redir_valid = 1'b1;
         redir_pc    = 16'h0020;
         @(posedge clk); #1;
         redir_valid = 1'b0;
         check_val("redir_target", {bus.imem_req, bus.imem_addr, bus.iss_valid},
                   {1'b1, 16'h0020, 1'b0});
         run_to_halt("redir");
      end
`endif

      check_val("wrap_nfetch", w_addrs.size(), 3);
      if (w_addrs.size() == 3)
         for (int i = 0; i < 3; i++) check_val("wrap_addr", w_addrs[i], wrap_exp[i]);
      check_val("wrap_iadd_issue", {w_first_seen, w_first}, {1'b1, T_IADD, 16'h1234, 4'hF});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
